// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave controller: FSM states, frame opcodes, default width.
package spi_pkg;

  localparam int ADDR_SIZE_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // True when a completed frame's opcode belongs to the state that received it.
  function automatic logic op_matches(input state_e st, input logic [1:0] op);
    case (st)
      WRITE:     return (op == OP_WR_ADDR) || (op == OP_WR_DATA);
      READ_ADD:  return op == OP_RD_ADDR;
      READ_DATA: return op == OP_RD_DATA;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Read-data serializer: load captures a word, each shift edge drives the next bit MSB first on miso.
// miso is registered (bit appears the edge after shift is sampled) and is 0 on any edge without shift.
module spi_tx_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] tx_dat,
  output logic             miso
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic             miso_q, miso_d;

  always_comb begin
    sr_d   = sr_q;
    miso_d = 1'b0;
    if (load) begin
      sr_d = tx_dat;
    end else if (shift) begin
      miso_d = sr_q[WIDTH-1];
      sr_d   = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q   <= '0;
      miso_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave framer: command bit + ADDR_SIZE+2 frame bits -> rx_data/rx_valid one edge after the last bit;
// read-data frames then wait for tx_valid and serialize tx_data on miso. SPI_CTRL_CMD_CHECK_EN enables opcode checking.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 cmd_err
);

  localparam int FW    = ADDR_SIZE + 2;
  localparam int CNT_W = $clog2(2 * ADDR_SIZE + 5);

  // Counter phases inside a frame state: bits in, completion, post/await, bits out, done.
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FW);
  localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(FW + 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(FW + 2 + ADDR_SIZE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    sr_q, sr_d;
  logic [FW-1:0]    rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rd_addr_seen_q, rd_addr_seen_d;
  logic             in_frame, frame_done, op_good;
  logic             tx_load, tx_shift;

  assign in_frame   = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
  assign frame_done = in_frame && !ss_n && (cnt_q == CNT_DONE);

`ifdef SPI_CTRL_CMD_CHECK_EN
  logic cmd_err_q, cmd_err_d;

  assign op_good = op_matches(state_q, sr_q[FW-1 -: 2]);

  always_comb begin
    cmd_err_d = frame_done && !op_good;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= cmd_err_d;
    end
  end

  assign cmd_err = cmd_err_q;
`else
  assign op_good = 1'b1;
  assign cmd_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sr_d           = sr_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_load        = 1'b0;
    tx_shift       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!ss_n) state_d = CHK_CMD;
      end

      CHK_CMD: begin
        cnt_d = '0;
        if (ss_n)                state_d = IDLE;
        else if (!mosi)          state_d = WRITE;
        else if (rd_addr_seen_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end

      default: begin
        // Deselect aborts any phase: partial frame and read-out are dropped, rd_addr_seen kept.
        if (ss_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q < CNT_DONE) begin
          sr_d  = {sr_q[FW-2:0], mosi};
          cnt_d = cnt_q + 1'b1;
        end else if (frame_done) begin
          if (op_good) begin
            cnt_d      = cnt_q + 1'b1;
            rx_data_d  = sr_q;
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (state_q != READ_DATA) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_POST) begin
          if (tx_valid) begin
            tx_load = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (cnt_q < CNT_END) begin
          tx_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end else begin
          state_d        = IDLE;
          cnt_d          = '0;
          rd_addr_seen_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sr_q           <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sr_q           <= sr_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  spi_tx_shifter #(
    .WIDTH (ADDR_SIZE)
  ) u_tx_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tx_load),
    .shift  (tx_shift),
    .tx_dat (tx_data),
    .miso   (miso)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: directed frames, an expected-output timeline per clock edge, and literal spot checks.
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  localparam int A    = 8;
  localparam int W    = A + 2;
  localparam int MAXC = 4096;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         ss_n     = 1'b1;
  logic         mosi     = 1'b0;
  logic         tx_valid = 1'b0;
  logic [A-1:0] tx_data  = '0;
  logic         miso, rx_valid, cmd_err;
  logic [W-1:0] rx_data;

  spi_slave_ctrl #(.ADDR_SIZE(A)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; outputs seen at a falling edge belong to edge cyc.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs indexed by the edge that produces them.
  bit           exp_vld  [MAXC];
  bit           exp_err  [MAXC];
  bit           exp_miso [MAXC];
  bit           exp_rst  [MAXC];
  logic [W-1:0] exp_dat  [MAXC];

  int           n_tests  = 0;
  int           n_fail   = 0;
  bit           chk_en   = 1'b0;
  bit           mdl_seen = 1'b0;
  bit           tv_noise = 1'b0;
  logic [W-1:0] mdl_rxd  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      if (exp_rst[cyc]) mdl_rxd = '0;
      if (exp_vld[cyc]) mdl_rxd = exp_dat[cyc];
      check("rx_valid", 32'(rx_valid), 32'(exp_vld[cyc]));
      check("rx_data",  32'(rx_data),  32'(mdl_rxd));
      check("miso",     32'(miso),     32'(exp_miso[cyc]));
      check("cmd_err",  32'(cmd_err),  32'(exp_err[cyc]));
    end
  end

  // Drive inputs for the next rising edge (index cyc+1 on return).
  task automatic tick(input logic ss, input logic m, input logic tv);
    @(negedge clk);
    ss_n     = ss;
    mosi     = m;
    tx_valid = tv | tv_noise;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = cyc + 1; k < MAXC; k++) begin
        exp_vld[k]  = 1'b0;
        exp_err[k]  = 1'b0;
        exp_miso[k] = 1'b0;
      end
      exp_rst[cyc + 1] = 1'b1;
    end
    @(negedge clk);
    rst_n    = 1'b1;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    mdl_seen = 1'b0;
  endtask

  // Select, command bit, W bits MSB first, then the completion edge with ss_n = ss_done.
  task automatic send_frame(input logic cmd, input logic [W-1:0] bits, input logic ss_done,
                            output int done_e);
    bit rd_data, ok;
    rd_data = cmd && mdl_seen;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, cmd, 1'b0);
    for (int i = W - 1; i >= 0; i--) tick(1'b0, bits[i], 1'b0);
    tick(ss_done, 1'b0, 1'b0);
    done_e = cyc + 1;
    if (!ss_done) begin
`ifdef SPI_CTRL_CMD_CHECK_EN
      if (!cmd)         ok = (bits[W-1] == 1'b0);
      else if (rd_data) ok = (bits[W-1:W-2] == OP_RD_DATA);
      else              ok = (bits[W-1:W-2] == OP_RD_ADDR);
`else
      ok = 1'b1;
`endif
      if (ok) begin
        exp_vld[done_e] = 1'b1;
        exp_dat[done_e] = bits;
        if (cmd && !rd_data) mdl_seen = 1'b1;
      end else begin
        exp_err[done_e] = 1'b1;
      end
    end
  endtask

  // After a read-data frame: wait, present tx_data for one edge, observe n_obs miso bits.
  // A full read (n_obs == A) also runs the closing edge and deselects.
  task automatic read_out(input logic [A-1:0] d, input int wait_cyc, input int n_obs,
                          output logic [A-1:0] got);
    int t;
    got = '0;
    for (int i = 0; i < wait_cyc; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tx_data = d;
    t = cyc + 1;
    for (int k = 1; k <= A; k++) exp_miso[t + k] = d[A - k];
    for (int k = 0; k <= n_obs; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      tx_data = ~d;
      if (k >= 1) got = {got[A-2:0], miso};
    end
    if (n_obs == A) begin
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      mdl_seen = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int de;
    logic [A-1:0] got;

    // Reset state.
    do_reset(2);
    chk_en = 1'b1;
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_rx_data",  32'(rx_data),  32'h0);
    check("rst_miso",     32'(miso),     32'h0);
    check("rst_cmd_err",  32'(cmd_err),  32'h0);
    check("rst_state",    32'(dut.state_q), 32'(IDLE));

    // Write frame 00_0000_0101.
    send_frame(1'b0, 10'h005, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
    check("wr_rx_valid", 32'(rx_valid), 32'h1);
    check("wr_rx_data",  32'(rx_data),  32'h005);
    tick(1'b1, 1'b0, 1'b0);
    check("wr_rx_valid_drop", 32'(rx_valid), 32'h0);
    check("wr_state_idle",    32'(dut.state_q), 32'(IDLE));

    // Read address then read data 0xA5.
    send_frame(1'b1, 10'h205, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
    check("rda_rx_data", 32'(rx_data), 32'h205);
    tick(1'b1, 1'b0, 1'b0);
    send_frame(1'b1, 10'h3C3, 1'b0, de);
    read_out(8'hA5, 2, A, got);
    check("rd_miso_bits",  32'(got), 32'hA5);
    check("rd_seen_clear", 32'(dut.rd_addr_seen_q), 32'h0);

    // tx_valid outside the data wait must not disturb miso.
    tv_noise = 1'b1;
    send_frame(1'b0, 10'h1FF, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
    send_frame(1'b1, 10'h2AA, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
    tv_noise = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    send_frame(1'b1, 10'h3FF, 1'b0, de);
    read_out(8'h3C, 1, A, got);
    check("rd2_miso_bits", 32'(got), 32'h3C);

    // Deselect after 5 data bits, then a clean frame.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("abort_state_idle", 32'(dut.state_q), 32'(IDLE));
    send_frame(1'b0, 10'h0F0, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
    check("post_abort_rx_data", 32'(rx_data), 32'h0F0);

    // Aborted read-data frame keeps the read address pending.
    send_frame(1'b1, 10'h211, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    send_frame(1'b1, 10'h3E7, 1'b0, de);
    read_out(8'h81, 1, A, got);
    check("rd3_miso_bits", 32'(got), 32'h81);

    // Deselect on the completion edge: no strobe, rx_data keeps 0x3E7.
    send_frame(1'b0, 10'h0AB, 1'b1, de);
    tick(1'b1, 1'b0, 1'b0);
    check("late_ss_rx_data", 32'(rx_data), 32'h3E7);

    // Back-to-back frames with ss_n held low.
    send_frame(1'b0, 10'h123, 1'b0, de);
    tick(1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 10'h0BC, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
    check("b2b_rx_data", 32'(rx_data), 32'h0BC);

    // Write command carrying read-data opcode.
    send_frame(1'b0, 10'h300, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
`ifdef SPI_CTRL_CMD_CHECK_EN
    check("op_mismatch_err", 32'(cmd_err),  32'h1);
    check("op_mismatch_vld", 32'(rx_valid), 32'h0);
`else
    check("op_nocheck_vld",  32'(rx_valid), 32'h1);
    check("op_nocheck_data", 32'(rx_data),  32'h300);
`endif
    tick(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a read-data shift, ss_n still low.
    send_frame(1'b1, 10'h2F0, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
    send_frame(1'b1, 10'h3A0, 1'b0, de);
    read_out(8'h5A, 1, 3, got);
    check("pre_rst_bits", 32'(got[2:0]), 32'h2);
    do_reset(1);
    check("mid_rst_rx_data", 32'(rx_data), 32'h0);
    check("mid_rst_miso",    32'(miso),    32'h0);
    check("mid_rst_state",   32'(dut.state_q), 32'(IDLE));
    check("mid_rst_seen",    32'(dut.rd_addr_seen_q), 32'h0);
    send_frame(1'b1, 10'h2C4, 1'b0, de);
    tick(1'b1, 1'b0, 1'b0);
    check("post_rst_rda", 32'(rx_data), 32'h2C4);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8: RAM address/data width; frame width = ADDR_SIZE+2.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port ss_n, input, 1: SPI slave select, active-low.
REQ-005 SHALL have port mosi, input, 1: serial data in, MSB first.
REQ-006 SHALL have port miso, output, 1: serial data out, MSB first.
REQ-007 SHALL have port rx_data, output, ADDR_SIZE+2: assembled frame to RAM; [ADDR_SIZE+1:ADDR_SIZE] is the opcode.
REQ-008 SHALL have port rx_valid, output, 1: one-cycle strobe, rx_data valid.
REQ-009 SHALL have port tx_data, input, ADDR_SIZE: read data from RAM.
REQ-010 SHALL have port tx_valid, input, 1: tx_data valid.
REQ-011 SHALL have port cmd_err, output, 1: one-cycle opcode-mismatch strobe (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-013 IDLE -> CHK_CMD on any edge sampling ss_n=0.
REQ-014 CHK_CMD samples mosi as command bit, no shift: 0 -> WRITE; 1 and rd_addr_seen=0 -> READ_ADD; 1 and rd_addr_seen=1 -> READ_DATA.
REQ-015 WRITE/READ_ADD/READ_DATA shift exactly ADDR_SIZE+2 mosi bits, MSB first, one per edge, via a counter.
REQ-016 After the last bit is sampled, rx_data and rx_valid=1 SHALL be registered on the next edge; rx_valid high exactly one cycle; rx_data holds until the next frame.
REQ-017 WRITE and READ_ADD return to IDLE after the rx_valid cycle; READ_ADD sets rd_addr_seen=1.
REQ-018 READ_DATA after rx_valid waits for tx_valid=1, captures tx_data, then drives miso with ADDR_SIZE bits, MSB first, first bit the edge after tx_valid sampled, one bit per edge; then clears rd_addr_seen and returns to IDLE.
REQ-019 miso SHALL be 0 whenever not shifting read data.
REQ-020 tx_valid while not awaiting read data SHALL be ignored.
REQ-021 ss_n sampled 1 in any non-IDLE state SHALL force IDLE next edge, discard partial frame, emit no rx_valid, keep rd_addr_seen unchanged.
REQ-022 ss_n rising on the same edge the last bit is sampled: bit counts (sampled low earlier), frame SHALL abort; no rx_valid.
REQ-023 ss_n low continuously after a frame SHALL re-enter CHK_CMD the edge after returning to IDLE.

Reset
REQ-024 rst_n=0 at an edge SHALL set state IDLE, rx_data 0, rx_valid 0, miso 0, cmd_err 0, counter 0, rd_addr_seen 0, overriding all other inputs, including mid-frame.

Configuration
REQ-025 Macro SPI_CTRL_CMD_CHECK_EN defined: on frame completion, opcode not matching state (WRITE: 00/01, READ_ADD: 10, READ_DATA: 11) SHALL suppress rx_valid, pulse cmd_err one cycle, go IDLE, leave rd_addr_seen unchanged.
REQ-026 Macro undefined: no opcode check; cmd_err tied 0; rx_valid always issued.

Structure
REQ-027 Package spi_pkg SHALL hold state enum, opcode constants (OP_WR_ADDR=00, OP_WR_DATA=01, OP_RD_ADDR=10, OP_RD_DATA=11), default ADDR_SIZE.
REQ-028 SHALL instantiate one sub-module spi_tx_shifter (load, shift, miso) for the read-data serializer.

Verification
REQ-029 Write frame: ss_n low, cmd 0, bits 00_0000_0101 -> rx_valid one cycle, rx_data=0x005, state IDLE.
REQ-030 Read sequence: cmd 1, 10_0000_0101 -> rx_valid, rx_data=0x205; cmd 1, 11_xxxx_xxxx, tx_valid with tx_data=0xA5 -> miso 1,0,1,0,0,1,0,1 on consecutive edges, rd_addr_seen cleared.
REQ-031 ss_n high after 5 data bits -> IDLE, no rx_valid; next frame decodes correctly.
REQ-032 rst_n low mid-READ_DATA shift -> next edge all outputs 0, state IDLE, rd_addr_seen 0.
REQ-033 SPI_CTRL_CMD_CHECK_EN defined: cmd 0 with 11_0000_0000 -> cmd_err one cycle, no rx_valid; undefined -> rx_valid, rx_data=0x300.
